// File: rtl/if_id_pipe.sv
// Fetch-to-decode pipeline register with a two-entry skid buffer.
// in_ready depends on registered occupancy only, so no out_ready -> in_ready path exists.
module if_id_pipe #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned INST_W    = 32,
  parameter int unsigned STALL_IDX = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  output logic [15:0]       bubble_cnt
);

  localparam int unsigned EntW = PC_W + INST_W;

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [EntW-1:0] head_q, head_d;
  logic [EntW-1:0] skid_q, skid_d;
  logic [15:0]     bubble_q, bubble_d;
  logic            acc_in, acc_out;

  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q != StEmpty);
  assign acc_in    = in_valid & in_ready & ~flush;
  assign acc_out   = out_valid & out_ready & ~stall[STALL_IDX] & ~flush;

  // Empty stage presents an all-zero bubble; SKID is never visible on the outputs.
  assign out_pc     = out_valid ? head_q[EntW-1:INST_W] : '0;
  assign out_inst   = out_valid ? head_q[INST_W-1:0] : '0;
  assign bubble_cnt = bubble_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (acc_in) begin
            head_d  = {in_pc, in_inst};
            state_d = StOne;
          end
        end
        StOne: begin
          if (acc_in && acc_out) begin
            head_d = {in_pc, in_inst};
          end else if (acc_in) begin
            skid_d  = {in_pc, in_inst};
            state_d = StTwo;
          end else if (acc_out) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (acc_out) begin
            head_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (!out_valid && out_ready && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StEmpty;
      head_q   <= '0;
      skid_q   <= '0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
      bubble_q <= bubble_d;
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe: directed cycle tables plus a scoreboard monitor.
module tb_if_id_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready = 1'b0;
  logic [15:0] bubble_cnt;

  int total = 0;
  int bad = 0;
  int seen_300 = 0;

  logic [63:0] sb_q[$];
  logic [15:0] bubble_m = '0;

  if_id_pipe #(
    .PC_W     (32),
    .INST_W   (32),
    .STALL_IDX(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], 16'hC0DE};
  endfunction

  // Scoreboard monitor: samples mid-cycle, predicts the coming edge.
  always @(negedge clk) begin
    logic        mv, ain, aout;
    logic [63:0] exp_e;
    mv = (sb_q.size() != 0);
    check("mon_in_ready", {63'd0, in_ready}, {63'd0, sb_q.size() < 2});
    check("mon_out_valid", {63'd0, out_valid}, {63'd0, mv});
    check("mon_bubble", {48'd0, bubble_cnt}, {48'd0, bubble_m});
    if (!mv) check("mon_bubble_pc", {out_pc, out_inst}, 64'd0);
    if (out_valid && out_pc == 32'h300) seen_300++;
    if (rst) begin
      sb_q.delete();
      bubble_m = '0;
    end else begin
      if (!mv && out_ready && bubble_m != 16'hFFFF) bubble_m = bubble_m + 16'd1;
      if (flush) begin
        sb_q.delete();
      end else begin
        ain  = in_valid && (sb_q.size() < 2);
        aout = mv && out_ready && !stall[1];
        if (aout) begin
          exp_e = sb_q.pop_front();
          check("mon_order", {out_pc, out_inst}, exp_e);
        end
        if (ain) sb_q.push_back({in_pc, in_inst});
      end
    end
  end

  // Drive one cycle, check outputs mid-cycle against hand-computed values.
  task automatic cyc(input logic st, input logic fl, input logic iv, input logic [31:0] pc,
                     input logic ordy, input logic eir, input logic eov,
                     input logic [31:0] epc);
    stall     = {4'd0, st, 1'b0};
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst_of(pc);
    out_ready = ordy;
    @(negedge clk);
    check("dir_in_ready", {63'd0, in_ready}, {63'd0, eir});
    check("dir_out_valid", {63'd0, out_valid}, {63'd0, eov});
    check("dir_out_pc", {32'd0, out_pc}, {32'd0, epc});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    stall = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_pc", {32'd0, out_pc}, 64'd0);
    check("rst_bubble", {48'd0, bubble_cnt}, 64'd0);
    @(posedge clk);
    #1;

    // Back-to-back stream, each pc one cycle after acceptance.
    cyc(0, 0, 1, 32'h100, 1, 1, 0, 32'h000);
    cyc(0, 0, 1, 32'h104, 1, 1, 1, 32'h100);
    cyc(0, 0, 1, 32'h108, 1, 1, 1, 32'h104);
    cyc(0, 0, 1, 32'h10C, 1, 1, 1, 32'h108);
    cyc(0, 0, 1, 32'h110, 1, 1, 1, 32'h10C);
    cyc(0, 0, 0, 32'h000, 1, 1, 1, 32'h110);
    cyc(0, 0, 0, 32'h000, 1, 1, 0, 32'h000);

    // Stall for 4 cycles: two accepts fill the skid, then release.
    cyc(1, 0, 1, 32'h200, 1, 1, 0, 32'h000);
    cyc(1, 0, 1, 32'h204, 1, 1, 1, 32'h200);
    cyc(1, 0, 1, 32'h208, 1, 0, 1, 32'h200);
    cyc(1, 0, 1, 32'h208, 1, 0, 1, 32'h200);
    cyc(0, 0, 1, 32'h208, 1, 0, 1, 32'h200);
    cyc(0, 0, 1, 32'h208, 1, 1, 1, 32'h204);
    cyc(0, 0, 0, 32'h000, 1, 1, 1, 32'h208);
    cyc(0, 0, 0, 32'h000, 1, 1, 0, 32'h000);

    // Flush in TWO with a simultaneous input.
    cyc(0, 0, 1, 32'h280, 0, 1, 0, 32'h000);
    cyc(0, 0, 1, 32'h284, 0, 1, 1, 32'h280);
    cyc(0, 1, 1, 32'h300, 1, 0, 1, 32'h280);
    cyc(0, 0, 0, 32'h000, 1, 1, 0, 32'h000);
    cyc(0, 0, 0, 32'h000, 1, 1, 0, 32'h000);
    check("flush_drop_300", seen_300, 64'd0);

    // Bubble counter saturation.
    do_reset();
    out_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk);
    check("bubble_sat", {48'd0, bubble_cnt}, 64'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bubble_hold", {48'd0, bubble_cnt}, 64'hFFFF);
    @(posedge clk);
    #1;

    // Reset while in TWO.
    cyc(0, 0, 1, 32'h400, 0, 1, 0, 32'h000);
    cyc(0, 0, 1, 32'h404, 0, 1, 1, 32'h400);
    rst = 1'b1;
    stall = 6'b000010;
    flush = 1'b1;
    in_valid = 1'b1;
    in_pc = 32'h408;
    in_inst = inst_of(32'h408);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall = '0;
    flush = 1'b0;
    in_pc = 32'h500;
    in_inst = inst_of(32'h500);
    out_ready = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst2_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst2_bubble", {48'd0, bubble_cnt}, 64'd0);
    check("rst2_out_pc", {32'd0, out_pc}, 64'd0);
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 32'h000, 1, 1, 1, 32'h500);
    cyc(0, 0, 0, 32'h000, 1, 1, 0, 32'h000);

    // Random traffic against the scoreboard, plus out_ready -> in_ready isolation.
    for (int i = 0; i < 10000; i++) begin
      logic ir0;
      in_valid  = $urandom_range(0, 3) != 0;
      in_pc     = 32'h10000 + 32'(i) * 4;
      in_inst   = inst_of(in_pc);
      out_ready = $urandom_range(0, 3) != 0;
      stall     = 6'($urandom) & 6'b111101;
      stall[1]  = $urandom_range(0, 3) == 0;
      flush     = $urandom_range(0, 31) == 0;
      #1;
      ir0 = in_ready;
      out_ready = ~out_ready;
      #1;
      check("no_comb_path", {63'd0, in_ready}, {63'd0, ir0});
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
    end

    // Drain: everything still held must come out.
    in_valid = 1'b0;
    flush = 1'b0;
    stall = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drain_empty", {63'd0, out_valid}, 64'd0);
    check("drain_in_ready", {63'd0, in_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
